bcd_scan_display: RTL
=====================

// Module: bcd_scan_display
// PURPOSE
//   Next-generation countdown display driver for the traffic-light controller.
//   Converts a binary count to pLED_NO BCD digits with a sequential shift-add-3
//   (double-dabble) engine, then encodes each digit to 7-segment form.
//   Adds leading-zero blanking, overflow indication, and a time-multiplexed scan output.
//   Sits between the phase timer and the per-direction LED modules.
// PARAMETERS
//   pNUMBER_WIDTH  5   width of binary input number (1..16)
//   pLED_WIDTH     8   segment bus width; 7 = {g..a}, 8 = {dp,g..a}; no other values allowed
//   pLED_NO        2   number of decimal digits driven (1..5)
//   pSCAN_DIV      4   clk cycles per scan slot (>=1)
// PORTS
//   clk          in   1                     system clock, all logic on rising edge
//   rst          in   1                     synchronous active-high reset
//   load         in   1                     request conversion of number (accepted only when busy=0)
//   number       in   pNUMBER_WIDTH         unsigned binary value to display
//   blank_lz     in   1                     leading-zero blanking enable, sampled with load
//   busy         out  1                     conversion in progress; load ignored
//   done         out  1                     1-cycle pulse: display_led/overflow just updated
//   overflow     out  1                     last value > 10^pLED_NO - 1
//   display_led  out  [pLED_NO][pLED_WIDTH] parallel segments, index 0 = units digit
//   scan_sel     out  pLED_NO               one-hot digit enable, active high
//   scan_seg     out  pLED_WIDTH            segments of digit selected by scan_sel
// BEHAVIOUR
//   Reset:
//     busy=0, done=0, overflow=0, display_led all 0 (blank), scan_sel=1 (digit 0),
//     scan_seg=0, scan prescaler=0, FSM=IDLE.
//   Segments: active high, bit0=a .. bit6=g, bit7 (dp, when pLED_WIDTH=8) always 0.
//     0..9 = 3F 06 5B 4F 66 6D 7D 07 7F 6F; blank = 00; dash = 40.
//   FSM states:
//     IDLE: load=1 latches number and blank_lz, clears BCD shift register,
//       sets iteration count = pNUMBER_WIDTH -> CONV; busy=1 from next cycle.
//     CONV: one bit per cycle, MSB first. Before each shift, every BCD nibble >=5
//       gets +3. Internal BCD register holds ceil(pNUMBER_WIDTH*log10(2))+1 nibbles,
//       enough for the full input range. After pNUMBER_WIDTH shifts -> UPDATE.
//     UPDATE: writes display_led and overflow, pulses done=1, busy=0 -> IDLE.
//   Latency: load accepted at edge T -> done and new display_led visible after edge T+pNUMBER_WIDTH+1.
//   Display output: display_led holds its previous value throughout CONV.
//   load while busy=1: ignored, not queued. load in the UPDATE cycle: ignored.
//   Overflow: any BCD digit at index >= pLED_NO nonzero -> overflow=1,
//     all display digits = dash (40). No blanking applies in this case.
//   Leading-zero blanking (latched blank_lz=1):
//     - Every digit above the most significant nonzero digit is blank (00).
//     - Digit 0 is never blanked; value 0 shows a single "0".
//   Scan:
//     - Prescaler counts 0..pSCAN_DIV-1 continuously, independent of the FSM.
//     - On wrap, scan_sel rotates left: digit 0 -> 1 -> ... -> pLED_NO-1 -> 0.
//     - scan_seg is registered, equal to display_led[k] for the digit k selected by
//       scan_sel in the same cycle. With pLED_NO=1, scan_sel is constant 1.
//   rst mid-conversion: abort, return to IDLE, blank display. No done pulse.
// TESTING
//   1. rst, then load number=17, blank_lz=0 -> done after 6 cycles;
//      display_led[0]=07, [1]=06; overflow=0.
//   2. load number=5, blank_lz=1 -> display_led[0]=6D, [1]=00;
//      load number=0, blank_lz=1 -> [0]=3F, [1]=00.
//   3. pNUMBER_WIDTH=7, load number=100 -> overflow=1, both digits=40;
//      then number=99 -> overflow=0, 6F/6F.
//   4. load 12, then pulse load with number=3 while busy -> ignored; only one done; display shows 12.
//   5. pSCAN_DIV=4, display=17 -> scan_sel 01 for 4 cycles (scan_seg=07),
//      then 10 for 4 cycles (scan_seg=06), repeat.
//   6. assert rst at cycle 3 of CONV -> busy=0, display all 00, no done, scan_sel=01.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Countdown display driver: serial double-dabble binary-to-BCD conversion,
// 7-segment encoding with blanking/overflow, and a time-multiplexed scan output.
module bcd_scan_display #(
  parameter int pNUMBER_WIDTH = 5,
  parameter int pLED_WIDTH    = 8,
  parameter int pLED_NO       = 2,
  parameter int pSCAN_DIV     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic [pNUMBER_WIDTH-1:0]            number,
  input  logic                                blank_lz,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow,
  output logic [pLED_NO-1:0][pLED_WIDTH-1:0]  display_led,
  output logic [pLED_NO-1:0]                  scan_sel,
  output logic [pLED_WIDTH-1:0]               scan_seg
);

  // Decimal digits of the largest input value, plus one spare nibble.
  function automatic int req_digits(input int w);
    logic [31:0] v;
    int          n;
    v = (32'd1 << w) - 32'd1;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      if (v >= 32'd10) begin
        v = v / 32'd10;
        n = n + 1;
      end else begin
        v = v;
      end
    end
    return n + 1;
  endfunction

  localparam int REQ_DIG = req_digits(pNUMBER_WIDTH);
  localparam int NB      = (REQ_DIG > pLED_NO) ? REQ_DIG : pLED_NO;
  localparam int BW      = 4 * NB;
  localparam int CW      = $clog2(pNUMBER_WIDTH + 1);
  localparam int PW      = (pSCAN_DIV > 1) ? $clog2(pSCAN_DIV) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  function automatic logic [pLED_WIDTH-1:0] seg7(input logic [3:0] d);
    logic [6:0]            s;
    logic [pLED_WIDTH-1:0] r;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    r      = '0;
    r[6:0] = s;
    return r;
  endfunction

  function automatic logic [pLED_WIDTH-1:0] seg_dash();
    logic [pLED_WIDTH-1:0] r;
    r      = '0;
    r[6:0] = 7'h40;
    return r;
  endfunction

  logic [1:0]                             state_r;
  logic [pNUMBER_WIDTH-1:0]               num_r;
  logic [BW-1:0]                          bcd_r;
  logic [CW-1:0]                          cnt_r;
  logic                                   blank_r;
  logic [PW-1:0]                          presc_r;

  logic [BW-1:0]                          bcd_adj_s;
  logic [BW-1:0]                          bcd_shift_s;
  logic                                   ovf_s;
  logic                                   nz_s;
  logic [3:0]                             dig_s;
  logic [pLED_NO-1:0][pLED_WIDTH-1:0]     disp_new_s;
  logic [pLED_NO-1:0][pLED_WIDTH-1:0]     disp_next_s;
  logic                                   wrap_s;
  logic [pLED_NO-1:0]                     sel_rot_s;
  logic [pLED_NO-1:0]                     sel_next_s;
  logic [pLED_WIDTH-1:0]                  seg_next_s;

  // Add-3 correction on every nibble, then shift in the next input bit.
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int k = 0; k < NB; k++) begin
      if (bcd_r[4*k +: 4] >= 4'd5) begin
        bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4];
      end
    end
    bcd_shift_s = BW'({bcd_adj_s, num_r[pNUMBER_WIDTH-1]});
  end

  // Segment image of the finished BCD value, scanned from the top digit down for blanking.
  always_comb begin
    ovf_s      = 1'b0;
    nz_s       = 1'b0;
    dig_s      = 4'd0;
    disp_new_s = '0;
    for (int k = pLED_NO; k < NB; k++) begin
      ovf_s = ovf_s | (bcd_r[4*k +: 4] != 4'd0);
    end
    for (int k = pLED_NO - 1; k >= 0; k--) begin
      dig_s = bcd_r[4*k +: 4];
      if (ovf_s) begin
        disp_new_s[k] = seg_dash();
      end else if (blank_r && (k != 0) && !nz_s && (dig_s == 4'd0)) begin
        disp_new_s[k] = '0;
      end else begin
        disp_new_s[k] = seg7(dig_s);
      end
      nz_s = nz_s | (dig_s != 4'd0);
    end
  end

  // Next scan slot and the segments it will show, so scan_seg tracks scan_sel in the same cycle.
  always_comb begin
    wrap_s      = (presc_r == PW'(pSCAN_DIV - 1));
    sel_rot_s   = (scan_sel << 1) | (scan_sel >> (pLED_NO - 1));
    sel_next_s  = wrap_s ? sel_rot_s : scan_sel;
    disp_next_s = (state_r == UPDATE) ? disp_new_s : display_led;
    seg_next_s  = '0;
    for (int k = 0; k < pLED_NO; k++) begin
      seg_next_s = seg_next_s | (disp_next_s[k] & {pLED_WIDTH{sel_next_s[k]}});
    end
  end

  // Conversion FSM and display/overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      num_r       <= '0;
      bcd_r       <= '0;
      cnt_r       <= '0;
      blank_r     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      display_led <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load) begin
            num_r   <= number;
            blank_r <= blank_lz;
            bcd_r   <= '0;
            cnt_r   <= CW'(pNUMBER_WIDTH);
            busy    <= 1'b1;
            state_r <= CONV;
          end
        end
        CONV: begin
          bcd_r <= bcd_shift_s;
          num_r <= num_r << 1;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= UPDATE;
          end
        end
        UPDATE: begin
          display_led <= disp_new_s;
          overflow    <= ovf_s;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Free-running scan prescaler and digit rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r  <= '0;
      scan_sel <= pLED_NO'(1);
      scan_seg <= '0;
    end else begin
      presc_r  <= wrap_s ? PW'(0) : presc_r + PW'(1);
      scan_sel <= sel_next_s;
      scan_seg <= seg_next_s;
    end
  end

endmodule
